alu_rr_sched: RTL and testbench
===============================

Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares the single combinational ALU (32-bit a/b, 3-bit f, outputs y and z) among N_REQ requesters.
- Each requester presents an operation with valid/ready. The scheduler latches the operation, drives the ALU for one cycle, registers the result and returns it to the winning requester with valid/ready.
- Sits between the datapath clients and the ALU instance. It is the only driver of the ALU inputs.

Parameters:
- N_REQ, 2, number of requesters; legal range 2..8.
- DW, 32, operand/result width; must match the ALU.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  N_REQ  requester i has an operation pending.
- req_ready  out  N_REQ  one-hot; operation of requester i accepted this cycle.
- req_a  in  N_REQ*DW  operand a; slice i = [i*DW +: DW].
- req_b  in  N_REQ*DW  operand b; same slicing.
- req_f  in  N_REQ*3  opcode; slice i = [i*3 +: 3].
- rsp_valid  out  N_REQ  one-hot; result available for requester i.
- rsp_ready  in  N_REQ  requester i consumes the result.
- rsp_y  out  DW  registered result, shared by all requesters.
- rsp_z  out  1  registered zero flag.
- alu_a  out  DW  to ALU a.
- alu_b  out  DW  to ALU b.
- alu_f  out  3  to ALU f.
- alu_y  in  DW  from ALU y.
- alu_z  in  1  from ALU z.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - state=IDLE
  - last_grant=N_REQ-1, so requester 0 has first priority
  - op registers (a, b, f) and result registers (y, z) = 0
  - hence alu_a/alu_b/alu_f = 0 and rsp_y/rsp_z = 0
  - req_ready=0, rsp_valid=0, busy=0
- FSM has three states:
  - IDLE: if any req_valid bit is set, grant g = first set bit scanning last_grant+1, last_grant+2, ... modulo N_REQ.
    - req_ready[g]=1 combinationally in this cycle only; all other ready bits are 0.
    - Latch req_a/b/f slice g and g itself; go to EXEC.
    - With no valid request, stay in IDLE.
  - EXEC: alu_a/b/f driven from the latched registers; they are stable from the IDLE->EXEC edge onward.
    - At the end of EXEC, register alu_y into rsp_y and alu_z into rsp_z; go to RESP.
  - RESP: rsp_valid[g]=1.
    - When rsp_ready[g]=1: last_grant<=g, go to IDLE.
    - Otherwise hold; rsp_y/rsp_z are stable while waiting.
- Latency: accept at cycle T (IDLE), rsp_valid from T+2; minimum 3 cycles per operation.
- No new request is accepted before the response handshake completes; req_ready is 0 in EXEC and RESP.
- rsp_ready bits other than g are ignored. req_valid deasserting after acceptance has no effect.
- Opcodes 101..111 pass through to the ALU unchanged; the ALU returns y=0, z=0.
- Fairness: with all N_REQ requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0...
- Reset mid-operation (EXEC or RESP): the in-flight result is discarded and no response is issued; on release the FSM is back in IDLE with priority at requester 0.
- The scheduler does not depend on req_valid being held, but requesters must hold operands stable while req_valid is high and not yet accepted.

Optional Feature:
- Macro: ALU_RR_SCHED_ILLEGAL_OP_EN.
- When defined:
  - extra output rsp_err (1 bit, reset 0) is registered at EXEC.
  - rsp_err = 1 if the latched f is 101..111.
  - For illegal ops, rsp_y is forced to 0 and rsp_z to 0; the timing of the response is unchanged.
- When undefined: no rsp_err port; illegal opcodes return whatever the ALU produces.

Decomposition:
- Package alu_pkg:
  - opcode constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_XOR=3'b100
  - ALU_OP_W=3
  - sched_state_t enum {IDLE, EXEC, RESP}
- One sub-module: rr_pick. It is a combinational round-robin priority picker with inputs req[N_REQ] and last[$clog2(N_REQ)], and outputs gnt_onehot, gnt_idx and any.
- The ALU is instantiated by the parent, not by alu_rr_sched.

Test Plan:
- Reset then single request: req0 a=5, b=3, f=000 -> req_ready[0] in cycle 0, rsp_valid[0] in cycle 2 with rsp_y=8, rsp_z=0. With rsp_ready[0] high, busy is low in cycle 3.
- Zero flag: req1 a=7, b=7, f=001 -> rsp_y=0, rsp_z=1 to requester 1 only; rsp_valid[0] stays 0.
- Contention, N_REQ=4, all valid continuously with distinct XOR ops -> grant order 0,1,2,3,0 and each rsp_y correct. A requester that drops req_valid is skipped.
- Back-pressure: rsp_ready[0] held low 5 cycles in RESP -> rsp_valid[0] and rsp_y stay stable and req_ready stays 0. Releasing it returns the FSM to IDLE next cycle.
- Async reset asserted mid-EXEC (a=1, b=1, f=000) -> outputs zero immediately, no response issued. After release, a request from req1 with req0 idle is still granted.
- Illegal op with macro defined: f=110, a=9, b=9 -> rsp_y=0, rsp_z=0, rsp_err=1. The same stimulus without the macro yields y=0, z=0 and no rsp_err port.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, scheduler state type and opcode helper for the
// ALU round-robin scheduler.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  // Codes above XOR have no ALU function behind them.
  function automatic logic is_illegal_op(input logic [ALU_OP_W-1:0] f);
    return (f > ALU_XOR);
  endfunction

endpackage

// File: rtl/alu_rr_sched_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last+1, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [IW-1:0]    gnt_idx,
  output logic             any
);

  int idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = 0;
    // k = N_REQ lands back on 'last' itself, so it has lowest priority.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = IW'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one combinational ALU among N_REQ requesters.
// Optional ALU_RR_SCHED_ILLEGAL_OP_EN adds rsp_err and zeroes illegal-op results.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*DW-1:0]      req_a,
  input  logic [N_REQ*DW-1:0]      req_b,
  input  logic [N_REQ*ALU_OP_W-1:0] req_f,
  output logic [N_REQ-1:0]         rsp_valid,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic [DW-1:0]            rsp_y,
  output logic                     rsp_z,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  output logic [ALU_OP_W-1:0]      alu_f,
  input  logic [DW-1:0]            alu_y,
  input  logic                     alu_z,
  output logic                     busy
`ifdef ALU_RR_SCHED_ILLEGAL_OP_EN
  ,
  output logic                     rsp_err
`endif
);

  localparam int IW = $clog2(N_REQ);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high. req_ready is a one-cycle grant pulse in IDLE; rsp_valid
  // holds (with stable rsp_y/rsp_z) until the granted rsp_ready bit is seen.

  sched_state_t        state, next_state;
  logic [IW-1:0]       last_grant;
  logic [IW-1:0]       grant;
  logic [DW-1:0]       op_a, op_b;
  logic [ALU_OP_W-1:0] op_f;
  logic [DW-1:0]       res_y;
  logic                res_z;

  logic [N_REQ-1:0]    pick_onehot;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic                load;
  logic                done;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req        (req_valid),
    .last       (last_grant),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  always_comb begin
    next_state = state;
    req_ready  = '0;
    rsp_valid  = '0;
    load       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          req_ready  = pick_onehot;
          load       = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        next_state = RESP;
      end
      RESP: begin
        rsp_valid[grant] = 1'b1;
        if (rsp_ready[grant]) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IW'(N_REQ - 1);
      grant      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_f       <= '0;
    end else begin
      state <= next_state;
      if (load) begin
        grant <= pick_idx;
        op_a  <= req_a[int'(pick_idx)*DW +: DW];
        op_b  <= req_b[int'(pick_idx)*DW +: DW];
        op_f  <= req_f[int'(pick_idx)*ALU_OP_W +: ALU_OP_W];
      end
      if (done) last_grant <= grant;
    end
  end

`ifdef ALU_RR_SCHED_ILLEGAL_OP_EN
  logic res_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_y   <= '0;
      res_z   <= 1'b0;
      res_err <= 1'b0;
    end else if (state == EXEC) begin
      if (is_illegal_op(op_f)) begin
        res_y   <= '0;
        res_z   <= 1'b0;
        res_err <= 1'b1;
      end else begin
        res_y   <= alu_y;
        res_z   <= alu_z;
        res_err <= 1'b0;
      end
    end
  end

  assign rsp_err = res_err;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_y <= '0;
      res_z <= 1'b0;
    end else if (state == EXEC) begin
      res_y <= alu_y;
      res_z <= alu_z;
    end
  end
`endif

  // Operand registers drive the ALU directly, so its inputs only move on a grant.
  assign alu_a = op_a;
  assign alu_b = op_b;
  assign alu_f = op_f;
  assign rsp_y = res_y;
  assign rsp_z = res_z;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched with four requesters and a behavioural ALU.
module tb_alu_rr_sched;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [11:0]  req_f;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [31:0]  rsp_y;
  logic         rsp_z;
  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  logic [2:0]   alu_f;
  logic [31:0]  alu_y;
  logic         alu_z;
  logic         busy;
`ifdef ALU_RR_SCHED_ILLEGAL_OP_EN
  logic         rsp_err;
`endif

  int total = 0;
  int bad   = 0;

  alu_rr_sched #(
    .N_REQ (4),
    .DW    (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_f     (req_f),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_z     (rsp_z),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .alu_y     (alu_y),
    .alu_z     (alu_z),
    .busy      (busy)
`ifdef ALU_RR_SCHED_ILLEGAL_OP_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference ALU: undefined opcodes give y=0, z=0
  always_comb begin
    case (alu_f)
      3'b000:  alu_y = alu_a + alu_b;
      3'b001:  alu_y = alu_a - alu_b;
      3'b010:  alu_y = alu_a & alu_b;
      3'b011:  alu_y = alu_a | alu_b;
      3'b100:  alu_y = alu_a ^ alu_b;
      default: alu_y = 32'h0;
    endcase
    alu_z = (alu_f <= 3'b100) ? (alu_y == 32'h0) : 1'b0;
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f);
    req_valid[i]      = 1'b1;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_f[i*3 +: 3]   = f;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered settled in IDLE; runs one grant through to its response.
  task automatic do_op(input int idx, input logic [31:0] exp_y, input logic exp_z,
                       input bit drop);
    chk("grant", 32'(req_ready), 32'(4'b0001 << idx));
    tick();
    if (drop) req_valid = 4'b0000;
    #1;
    chk("exec_busy", 32'(busy), 32'd1);
    tick(); #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << idx));
    chk("rsp_y", rsp_y, exp_y);
    chk("rsp_z", 32'(rsp_z), 32'(exp_z));
    tick(); #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_f = '0; rsp_ready = '0;

    // reset values
    tick(); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_y", rsp_y, 32'd0);
    chk("rst_rsp_z", 32'(rsp_z), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_f", 32'(alu_f), 32'd0);
    rst_n = 1'b1;

    // single request: 5 + 3
    tick();
    set_req(0, 32'd5, 32'd3, 3'b000); rsp_ready = 4'b0001; #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = '0; #1;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready_exec", 32'(req_ready), 32'd0);
    chk("t1_alu_a", alu_a, 32'd5);
    chk("t1_alu_b", alu_b, 32'd3);
    chk("t1_alu_f", 32'(alu_f), 32'd0);
    chk("t1_no_rsp_exec", 32'(rsp_valid), 32'd0);
    tick(); #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_y", rsp_y, 32'd8);
    chk("t1_rsp_z", 32'(rsp_z), 32'd0);
    tick(); #1;
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_rsp", 32'(rsp_valid), 32'd0);

    // zero flag: 7 - 7 to requester 1 only
    set_req(1, 32'd7, 32'd7, 3'b001); rsp_ready = 4'b0010; #1;
    chk("t2_ready", 32'(req_ready), 32'h2);
    tick(); req_valid = '0; #1;
    tick(); #1;
    chk("t2_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("t2_rsp_y", rsp_y, 32'd0);
    chk("t2_rsp_z", 32'(rsp_z), 32'd1);
    tick(); #1;
    chk("t2_idle_busy", 32'(busy), 32'd0);

    // contention after reset: rotation 0,1,2,3,0, then skip dropped requester 1
    rst_n = 1'b0; #1; rst_n = 1'b1;
    set_req(0, 32'h0000_00FF, 32'h0000_000F, 3'b100);
    set_req(1, 32'h1234_5678, 32'hFFFF_0000, 3'b100);
    set_req(2, 32'hAAAA_AAAA, 32'h5555_5555, 3'b100);
    set_req(3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b100);
    rsp_ready = 4'hF; #1;
    do_op(0, 32'h0000_00F0, 1'b0, 1'b0);
    do_op(1, 32'hEDCB_5678, 1'b0, 1'b0);
    do_op(2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(3, 32'h0000_0000, 1'b1, 1'b0);
    do_op(0, 32'h0000_00F0, 1'b0, 1'b0);
    req_valid[1] = 1'b0; #1;
    do_op(2, 32'hFFFF_FFFF, 1'b0, 1'b1);

    // back-pressure: 10 - 4 held in RESP, other ready bits ignored
    set_req(0, 32'd10, 32'd4, 3'b001); rsp_ready = 4'b0000; #1;
    chk("t4_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = '0; set_req(1, 32'd3, 32'd5, 3'b010); #1;
    chk("t4_ready_exec", 32'(req_ready), 32'd0);
    tick(); rsp_ready = 4'b1110; #1;
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", 32'(rsp_valid), 32'h1);
      chk("t4_hold_y", rsp_y, 32'd6);
      chk("t4_hold_z", 32'(rsp_z), 32'd0);
      chk("t4_hold_ready", 32'(req_ready), 32'd0);
      chk("t4_hold_busy", 32'(busy), 32'd1);
      tick(); #1;
    end
    rsp_ready = 4'b0001; #1;
    chk("t4_release_valid", 32'(rsp_valid), 32'h1);
    tick(); #1;
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_next_grant", 32'(req_ready), 32'h2);
    rsp_ready = 4'b0010;
    tick(); req_valid = '0; #1;
    tick(); #1;
    chk("t4b_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("t4b_rsp_y", rsp_y, 32'd1);
    chk("t4b_rsp_z", 32'(rsp_z), 32'd0);
`ifdef ALU_RR_SCHED_ILLEGAL_OP_EN
    chk("t4b_rsp_err", 32'(rsp_err), 32'd0);
`endif
    tick(); #1;

    // async reset mid-EXEC discards the operation
    set_req(0, 32'd1, 32'd1, 3'b000); rsp_ready = 4'b0001; #1;
    chk("t5_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = '0; #1;
    chk("t5_exec_alu_a", alu_a, 32'd1);
    chk("t5_exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_alu_a", alu_a, 32'd0);
    chk("t5_rst_alu_b", alu_b, 32'd0);
    chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_rsp_y", rsp_y, 32'd0);
    chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
    tick(); rst_n = 1'b1; #1;
    tick(); #1;
    chk("t5_no_rsp_1", 32'(rsp_valid), 32'd0);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    tick(); #1;
    chk("t5_no_rsp_2", 32'(rsp_valid), 32'd0);
    set_req(1, 32'd2, 32'd9, 3'b011); rsp_ready = 4'b0010; #1;
    chk("t5_req1_grant", 32'(req_ready), 32'h2);
    tick(); req_valid = '0; #1;
    tick(); #1;
    chk("t5_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("t5_rsp_y", rsp_y, 32'h0000_000B);
    tick(); #1;

    // undefined opcode 110 passes through; result is zero
    set_req(2, 32'd9, 32'd9, 3'b110); rsp_ready = 4'b0100; #1;
    chk("t6_ready", 32'(req_ready), 32'h4);
    tick(); req_valid = '0; #1;
    chk("t6_alu_f", 32'(alu_f), 32'd6);
    tick(); #1;
    chk("t6_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("t6_rsp_y", rsp_y, 32'd0);
    chk("t6_rsp_z", 32'(rsp_z), 32'd0);
`ifdef ALU_RR_SCHED_ILLEGAL_OP_EN
    chk("t6_rsp_err", 32'(rsp_err), 32'd1);
`endif
    tick(); #1;
    chk("t6_idle_busy", 32'(busy), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
